// File: rtl/blinken_pkg.sv
// Shared encodings for the LED animation engine.
// Holds the mode constants sampled on start and the run/idle state type.
// No logic lives here.
package blinken_pkg;

  localparam logic [1:0] MODE_FILL   = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_STATIC = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/blinken_prescaler.sv
// Step-rate prescaler: counts 0..STEP_CYCLES-1 while enabled and flags the last count.
// tick is combinational from the registered count, asserted in the cycle count==STEP_CYCLES-1.
// No backpressure; clear restarts the count so the first tick lands STEP_CYCLES cycles later.
module blinken_prescaler #(
  parameter int STEP_CYCLES = 100_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(STEP_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // Free-run while enabled, wrap on the last count, hold otherwise.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/blinken_seq.sv
// LED animation engine: FILL, CHASE, BOUNCE or STATIC pattern on a WIDTH-bit bank.
// leds/done registered; a step lands STEP_CYCLES cycles after start, then every STEP_CYCLES.
// No backpressure; start overrides everything except reset, stop only acts while running.
module blinken_seq
  import blinken_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STEP_CYCLES = 100_000,
  parameter int AUTO_START  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] leds,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [1:0]       run_mode;
  logic             dir_down;
  logic             auto_pend;
  logic             tick;
  logic             go;
  logic [1:0]       go_mode;
  logic [WIDTH-1:0] nxt_leds;
  logic             nxt_down;

  // An explicit start beats the implicit power-on FILL if both land together.
  assign go      = start | auto_pend;
  assign go_mode = start ? mode : MODE_FILL;
  assign busy    = (state == RUN);

  // Remember that reset just released so the first free cycle launches a FILL.
  always_ff @(posedge clock) begin
    if (reset) auto_pend <= (AUTO_START != 0);
    else       auto_pend <= 1'b0;
  end

  blinken_prescaler #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(busy),
    .clear (go | stop),
    .tick  (tick)
  );

  // Next animation frame for the latched mode; only consumed on a tick.
  always_comb begin
    nxt_leds = leds;
    nxt_down = dir_down;
    case (run_mode)
      MODE_FILL:  nxt_leds = {leds[WIDTH-2:0], 1'b1};
      MODE_CHASE: nxt_leds = (leds == '0) ? ONE : {leds[WIDTH-2:0], leds[WIDTH-1]};
      MODE_BOUNCE: begin
        if (leds == '0) begin
          nxt_leds = ONE;
          nxt_down = 1'b0;
        end else if (!dir_down) begin
          nxt_leds = leds << 1;
          if (nxt_leds[WIDTH-1]) nxt_down = 1'b1;
        end else begin
          nxt_leds = leds >> 1;
          if (nxt_leds == ONE) nxt_down = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Run/idle control with registered LED drive and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      leds     <= '0;
      done     <= 1'b0;
      dir_down <= 1'b0;
      run_mode <= MODE_FILL;
    end else begin
      done <= 1'b0;
      if (go) begin
        if (go_mode == MODE_STATIC) begin
          state <= IDLE;
          leds  <= pattern;
          done  <= 1'b1;
        end else begin
          state    <= RUN;
          leds     <= '0;
          dir_down <= 1'b0;
          run_mode <= go_mode;
        end
      end else if (stop && state == RUN) begin
        state <= IDLE;
        leds  <= '0;
      end else if (state == RUN && tick) begin
        if (run_mode == MODE_FILL && (&leds)) begin
          state <= IDLE;
          leds  <= '0;
          done  <= 1'b1;
        end else begin
          leds     <= nxt_leds;
          dir_down <= nxt_down;
        end
      end
    end
  end

endmodule
